// File: rtl/fifo_level.sv
// Parametrised single-clock show-ahead FIFO with fill level, almost-full/empty thresholds and flush.
// Define FIFO_LEVEL_ERR_EN to build the sticky overflow/underflow flags and honour err_clear.
module fifo_level #(
    parameter int DATA_BITS     = 11,
    parameter int FIFO_LENGTH   = 16,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_BITS-1:0]         input_data,
    input  logic                         write,
    input  logic                         read,
    input  logic                         flush,
    input  logic                         err_clear,
    output logic [DATA_BITS-1:0]         output_data,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_empty,
    output logic                         almost_full,
    output logic [$clog2(FIFO_LENGTH):0] count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PTR_W = $clog2(FIFO_LENGTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_BITS-1:0] mem_r [FIFO_LENGTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     count_nxt_s;
    logic                 empty_s;
    logic                 full_s;
    logic                 wr_en_s;
    logic                 rd_en_s;

    // Flags come from the registered level, so they only move after an edge.
    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign full_s  = (count_r == CNT_W'(FIFO_LENGTH));
    assign wr_en_s = write && !full_s && !flush;
    assign rd_en_s = read && !empty_s && !flush;

    assign empty        = empty_s;
    assign full         = full_s;
    assign almost_empty = (count_r <= CNT_W'(AEMPTY_THRESH));
    assign almost_full  = (count_r >= CNT_W'(AFULL_THRESH));
    assign count        = count_r;
    assign output_data  = empty_s ? {DATA_BITS{1'b0}} : mem_r[rd_ptr_r];

    // Level update: a simultaneous accepted read and write leaves the level unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array, deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= input_data;
        end
    end

    // Pointers and level; flush returns them to zero ahead of any traffic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

`ifdef FIFO_LEVEL_ERR_EN
    logic overflow_r;
    logic underflow_r;
    logic ovf_evt_s;
    logic unf_evt_s;

    assign ovf_evt_s = write && full_s && !flush;
    assign unf_evt_s = read && empty_s && !flush;

    // Sticky error flags; a new event beats a coincident clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (ovf_evt_s) begin
                overflow_r <= 1'b1;
            end else if (err_clear) begin
                overflow_r <= 1'b0;
            end
            if (unf_evt_s) begin
                underflow_r <= 1'b1;
            end else if (err_clear) begin
                underflow_r <= 1'b0;
            end
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`else
    logic unused_err_clear_s;

    assign unused_err_clear_s = err_clear;
    assign overflow           = 1'b0;
    assign underflow          = 1'b0;
`endif

endmodule

// File: doc/fifo_level.md
Name: fifo_level

Overview:
- Parametrised synchronous FIFO; next generation of the team's single-clock data FIFO.
- Adds a fill-level output, almost-full and almost-empty thresholds, a synchronous flush, and defined simultaneous read/write and overflow/underflow behaviour.
- Show-ahead read port: the head word is visible on `output_data` before `read` is asserted.
- Used as the address/data buffer between AXI-side producers and downstream consumers.

Parameters:
- DATA_BITS, 11, width of each data word (≥1).
- FIFO_LENGTH, 16, depth in words; power of two, ≥2.
- AFULL_THRESH, 12, `almost_full` asserts when count ≥ this value (1..FIFO_LENGTH).
- AEMPTY_THRESH, 4, `almost_empty` asserts when count ≤ this value (0..FIFO_LENGTH-1).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- input_data  in  DATA_BITS  write data.
- write  in  1  write request.
- read  in  1  read request; pops the head word.
- flush  in  1  synchronous clear of contents.
- err_clear  in  1  synchronous clear of sticky error flags.
- output_data  out  DATA_BITS  head word (show-ahead).
- empty  out  1  count == 0.
- full  out  1  count == FIFO_LENGTH.
- almost_empty  out  1  count ≤ AEMPTY_THRESH.
- almost_full  out  1  count ≥ AFULL_THRESH.
- count  out  $clog2(FIFO_LENGTH)+1  current fill level.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Clock and reset: one clock `clk`. Reset is asynchronous, active-low, on port `reset`.
- Reset values:
  - `wr_ptr` = `rd_ptr` = 0, `count` = 0.
  - `empty` = 1, `full` = 0, `almost_empty` = 1, `almost_full` = 0.
  - `overflow` = `underflow` = 0, `output_data` = 0.
  - Storage array is not reset.
- Write acceptance: accepted iff `write` && !`full` at the clock edge. Word is stored at `mem[wr_ptr]`; `wr_ptr` increments, wrapping FIFO_LENGTH-1 → 0.
- Read acceptance: accepted iff `read` && !`empty`; `rd_ptr` increments with the same wrap.
- `output_data`: combinational `mem[rd_ptr]` when !`empty`; forced to 0 when `empty`.
- Write-to-read latency: a word written into an empty FIFO appears on `output_data`, with `empty` = 0, in the cycle after the accepting edge. No fall-through in the same cycle.
- Count update:
  - write only: +1; read only: −1.
  - both accepted: unchanged, both pointers advance.
- Status flags: `empty`, `full`, `almost_*` are decoded combinationally from the registered `count`, so they change only after a clock edge.
- Simultaneous read+write while empty: write accepted, read ignored, `underflow` set. Next cycle `count` = 1.
- Simultaneous read+write while full: read accepted, write dropped, `overflow` set. Next cycle `count` = FIFO_LENGTH-1.
- Error flags: `overflow` and `underflow` stay set until `err_clear` or reset. If a set event coincides with `err_clear`, the flag stays set (set wins).
- `flush`:
  - Next edge: pointers and `count` go to 0; read and write on that edge are ignored.
  - Error flags are not affected.
  - `flush` has priority over everything except reset.
- Reset mid-operation: immediate return to reset values; contents are discarded.
- Width rule: `count` has one extra bit so the value FIFO_LENGTH is representable. Pointers are $clog2(FIFO_LENGTH) bits and wrap naturally.

Optional Feature:
- Macro `FIFO_LEVEL_ERR_EN`.
- Defined: `overflow`/`underflow` behave as above; `err_clear` is honoured.
- Undefined: no error registers are built; `overflow` and `underflow` are tied to 0 and `err_clear` is ignored.
- Data path, flags and `count` are identical in both builds.

Test Plan:
- Reset release, no traffic → `empty`=1, `almost_empty`=1, `count`=0, `output_data`=0, `full`=0.
- Write 0..9 on consecutive cycles, no reads:
  - `count` goes 1..10.
  - `almost_empty` deasserts once `count` reaches 5.
  - `output_data`=0 from the cycle after the first write.
- Write 16 words (0..15), then one extra write of 99 → `full`=1, `almost_full`=1 at `count` 12, `overflow`=1. Draining reads 0..15 with no 99.
- `read`+`write` each cycle at `count` 8 for 20 cycles, write data 100..119:
  - `count` stays 8.
  - Data order preserved across pointer wrap.
- `read` while empty, then `err_clear` → `underflow`=1, then 0. `read`+`write` while empty gives `count`=1 and `underflow`=1.
- Fill 10 words, assert `flush` together with `read` and `write` → `count`=0 and `empty`=1 the next cycle, the write is dropped, `overflow`/`underflow` unchanged.
